pwm_fade_sequencer: RTL
=======================

// Module: pwm_fade_sequencer
// PURPOSE
//  Controller in front of the 4-bit PWM LED modulator: synchronizes/debounces the four
//  level switches, ramps the applied duty code toward the requested level one step per
//  STEP_MS ms, and hands the code to the modulator only on PWM-period boundaries.
//  Sits between board switches and the PWM generator; emits the period tick both use.
// PARAMETERS
//  PERIOD_CYCLES  27000  clk cycles per PWM period (1 ms at 27 MHz)
//  DEBOUNCE_MS    10     periods a synced switch value must be stable before accepted
//  STEP_MS        50     periods between successive +/-1 duty-code steps
//  LEVEL_W        4      duty-code width (16 levels)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        async, active-high reset
//  sw_i          in   LEVEL_W  raw switch levels (async to clk)
//  enable_i      in   1        0: target forced to 0 (fade out); 1: target = debounced sw
//  duty_code_o   out  LEVEL_W  duty code applied to PWM modulator
//  period_tick_o out  1        1-cycle pulse at last cycle of each PWM period
//  busy_o        out  1        1 while duty_code_o != target (ramp in progress)
//  state_o       out  2        FSM state (IDLE=0, RAMP_UP=1, RAMP_DOWN=2)
// BEHAVIOUR
//  Reset (async assert, sync release): period cnt=0, debounce cnt=0, step cnt=0,
//   target=0, duty_code_o=0, period_tick_o=0, busy_o=0, state_o=IDLE. Reset mid-ramp
//   aborts immediately; outputs 0 in the same instant.
//  Period counter: 0..PERIOD_CYCLES-1, wraps to 0; period_tick_o=1 when cnt==PERIOD_CYCLES-1.
//  Switch path: 2-FF synchronizer on sw_i. Debounce cnt clears whenever synced value
//   != candidate (candidate reloaded); increments on each period tick while equal;
//   at DEBOUNCE_MS ticks the candidate loads into debounced reg, cnt saturates.
//  Target = enable_i ? debounced : 0 (combinational from registers).
//  FSM, evaluated every cycle; duty changes only on period_tick_o:
//   IDLE: duty==target. target>duty -> RAMP_UP; target<duty -> RAMP_DOWN; step cnt=0.
//   RAMP_UP/DOWN: step cnt++ on each period tick; on the tick where step cnt reaches
//    STEP_MS-1: duty +/-1, step cnt=0. After each step re-compare: equal -> IDLE;
//    direction reversed (target moved across duty) -> other RAMP state, step cnt=0.
//   Target change mid-ramp without crossing: keep ramping, step cnt not reset.
//  Saturation: duty never exceeds 2^LEVEL_W-1 nor goes below 0 (no wrap).
//  Latency: sw_i change -> target: 2 clk + DEBOUNCE_MS period ticks (+<=1 period align).
//   target change -> first duty step: STEP_MS period ticks after FSM leaves IDLE.
//  busy_o = (state_o != IDLE), registered with state.
//  enable_i is synchronous (driven from clk domain); deassert mid-ramp -> ramp toward 0.
// STRUCTURE
//  pwm_pkg: typedef enum logic [1:0] fade_state_t {IDLE,RAMP_UP,RAMP_DOWN};
//   localparam defaults PERIOD_CYCLES, LEVEL_W shared with the PWM modulator.
//  Sub-module sw_debouncer (sync + stability counter, WIDTH/COUNT params, tick input).
//  Top: period counter, FSM, step counter, duty register.
// TESTING (sim params PERIOD_CYCLES=10, DEBOUNCE_MS=2, STEP_MS=3)
//  1 Reset: rst=1 at arbitrary time -> all outputs 0, state IDLE; release -> tick every 10 clk.
//  2 sw_i 0->4, enable=1 -> target 4 after 2clk+2 ticks; duty 1,2,3,4 every 3 ticks; IDLE, busy 0.
//  3 sw_i glitch 4->7->4 held 1 tick -> debounced stays 4, no duty change.
//  4 duty ramping up to 15 at 6, sw_i -> 2 -> RAMP_DOWN, step cnt cleared; duty 5,4,3,2.
//  5 duty=8, enable_i=0 -> ramps to 0 in 8 steps (24 ticks); at 0 stays 0, no underflow.
//  6 sw_i=15 from 0 -> duty reaches 15, holds; duty_code_o changes only in tick cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM LED path (fade sequencer and modulator).
package pwm_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RAMP_DOWN = 2'd2} fade_state_t;

   localparam int PERIOD_CYCLES_DEF = 27000;
   localparam int LEVEL_W_DEF       = 4;
endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Switch/enable inputs and duty/tick/status outputs of the fade sequencer.
interface pwm_fade_sequencer_if import pwm_pkg::*; #(parameter int LEVEL_W = LEVEL_W_DEF);
   logic [LEVEL_W-1:0] sw_i;
   logic               enable_i;
   logic [LEVEL_W-1:0] duty_code_o;
   logic               period_tick_o;
   logic               busy_o;
   logic [1:0]         state_o;

   modport master (output sw_i, enable_i,
                   input  duty_code_o, period_tick_o, busy_o, state_o);
   modport slave  (input  sw_i, enable_i,
                   output duty_code_o, period_tick_o, busy_o, state_o);
endinterface

// File: rtl/sw_debouncer.sv
// 2-FF synchronizer plus a stability counter advanced by an external tick.
module sw_debouncer #(
   parameter int WIDTH = 4,
   parameter int COUNT = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   localparam int            CW      = $clog2(COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(COUNT);

   logic [WIDTH-1:0] s1, s2, cand;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         cand <= '0;
         cnt  <= '0;
         q    <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         // Any disagreement restarts the stability window on the new value.
         if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
         end else if (tick && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) q <= cand;
         end
      end
   end
endmodule

// File: rtl/pwm_fade_sequencer.sv
// Ramps the PWM duty code toward the debounced switch level, one step per STEP_MS periods,
// updating only on the period tick it also exports to the modulator.
module pwm_fade_sequencer import pwm_pkg::*; #(
   parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
   parameter int DEBOUNCE_MS   = 10,
   parameter int STEP_MS       = 50,
   parameter int LEVEL_W       = LEVEL_W_DEF
) (
   input logic                 clk,
   input logic                 rst,
   pwm_fade_sequencer_if.slave bus
);
   localparam int                 PW          = $clog2(PERIOD_CYCLES + 1);
   localparam logic [PW-1:0]      PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam int                 SW          = $clog2(STEP_MS + 1);
   localparam logic [SW-1:0]      STEP_LAST   = SW'(STEP_MS - 1);
   localparam logic [LEVEL_W-1:0] DUTY_MAX    = '1;

   logic [PW-1:0]      pcnt;
   logic               tick;
   logic [LEVEL_W-1:0] deb, target;
   fade_state_t        state, state_nxt;
   logic [SW-1:0]      step, step_nxt;
   logic [LEVEL_W-1:0] duty, duty_nxt, duty_stp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pcnt <= '0;
      else     pcnt <= (pcnt == PERIOD_LAST) ? '0 : pcnt + 1'b1;
   end
   assign tick = (pcnt == PERIOD_LAST);

   sw_debouncer #(.WIDTH(LEVEL_W), .COUNT(DEBOUNCE_MS)) u_deb (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .d   (bus.sw_i),
      .q   (deb)
   );

   assign target = bus.enable_i ? deb : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         step  <= '0;
         duty  <= '0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         duty  <= duty_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      duty_nxt  = duty;
      duty_stp  = duty;
      case (state)
         IDLE: begin
            step_nxt = '0;
            if (target > duty)      state_nxt = RAMP_UP;
            else if (target < duty) state_nxt = RAMP_DOWN;
         end
         RAMP_UP, RAMP_DOWN: begin
            // Target landing on or crossing the duty is handled at once; a move that
            // keeps the direction just continues with the running step count.
            if (target == duty) begin
               state_nxt = IDLE;
               step_nxt  = '0;
            end else if ((state == RAMP_UP) != (target > duty)) begin
               state_nxt = (target > duty) ? RAMP_UP : RAMP_DOWN;
               step_nxt  = '0;
            end else if (tick) begin
               if (step == STEP_LAST) begin
                  step_nxt = '0;
                  if (state == RAMP_UP) duty_stp = (duty == DUTY_MAX) ? duty : duty + 1'b1;
                  else                  duty_stp = (duty == '0)       ? duty : duty - 1'b1;
                  duty_nxt = duty_stp;
                  if (target == duty_stp)     state_nxt = IDLE;
                  else if (target > duty_stp) state_nxt = RAMP_UP;
                  else                        state_nxt = RAMP_DOWN;
               end else begin
                  step_nxt = step + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            step_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      bus.duty_code_o   = duty;
      bus.period_tick_o = tick;
      bus.busy_o        = (state != IDLE);
      bus.state_o       = state;
   end
endmodule
